// File: rtl/axis_symbol_unpacker.sv
// axis_symbol_unpacker
// Splits each ITEM_W-bit input item into ITEM_W/SYM_W symbols and emits them
// one per output beat, zero-extended to OUT_W. Packet sideband is held for all
// symbols of a word, and a free-running counter tracks transferred symbols.
module axis_symbol_unpacker #(
  parameter int ITEM_W = 32,
  parameter int SYM_W  = 2,
  parameter int OUT_W  = 32
) (
  input  logic              axis_data_clk,
  input  logic              axis_data_rst_n,
  input  logic              cfg_msb_first,
  input  logic [ITEM_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [63:0]       s_axis_ttimestamp,
  input  logic              s_axis_thas_time,
  input  logic              s_axis_teov,
  input  logic              s_axis_teob,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [63:0]       m_axis_ttimestamp,
  output logic              m_axis_thas_time,
  output logic              m_axis_teov,
  output logic              m_axis_teob,
  output logic [31:0]       sym_count
);

  localparam int RATIO = ITEM_W / SYM_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Held word and its sideband
  logic [ITEM_W-1:0] word_q, word_d;
  logic              tlast_q, tlast_d;
  logic [63:0]       ts_q, ts_d;
  logic              has_time_q, has_time_d;
  logic              eov_q, eov_d;
  logic              eob_q, eob_d;
  logic              msb_q, msb_d;

  // Control state
  logic              full_q, full_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       sym_count_q, sym_count_d;

  logic              at_last;
  logic              m_hs;
  logic              s_rdy;
  logic              s_hs;
  logic [SYM_W-1:0]  sym;

  assign at_last = (idx_q == LAST_IDX);
  assign m_hs    = full_q && m_axis_tready;
  // A new item may enter in the same cycle the final symbol of the held word leaves.
  assign s_rdy   = !full_q || (m_axis_tready && at_last);
  assign s_hs    = s_axis_tvalid && s_rdy;

  // Pick the current symbol out of the held word according to the latched bit order.
  always_comb begin
    sym = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (idx_q == IDX_W'(k)) begin
        if (msb_q) sym = word_q[ITEM_W-1-k*SYM_W -: SYM_W];
        else       sym = word_q[k*SYM_W +: SYM_W];
      end
    end
  end

  // Next-state: load on input handshake, step or retire the word on output handshake.
  always_comb begin
    word_d      = word_q;
    tlast_d     = tlast_q;
    ts_d        = ts_q;
    has_time_d  = has_time_q;
    eov_d       = eov_q;
    eob_d       = eob_q;
    msb_d       = msb_q;
    full_d      = full_q;
    idx_d       = idx_q;
    sym_count_d = sym_count_q + (m_hs ? 32'd1 : 32'd0);

    if (s_hs) begin
      word_d     = s_axis_tdata;
      tlast_d    = s_axis_tlast;
      ts_d       = s_axis_ttimestamp;
      has_time_d = s_axis_thas_time;
      eov_d      = s_axis_teov;
      eob_d      = s_axis_teob;
      msb_d      = cfg_msb_first;
      full_d     = 1'b1;
      idx_d      = '0;
    end else if (m_hs) begin
      if (at_last) full_d = 1'b0;
      else         idx_d  = idx_q + IDX_W'(1);
    end
  end

  // State registers; reset clears the held word so outputs read zero while idle.
  always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
    if (!axis_data_rst_n) begin
      word_q      <= '0;
      tlast_q     <= 1'b0;
      ts_q        <= '0;
      has_time_q  <= 1'b0;
      eov_q       <= 1'b0;
      eob_q       <= 1'b0;
      msb_q       <= 1'b0;
      full_q      <= 1'b0;
      idx_q       <= '0;
      sym_count_q <= '0;
    end else begin
      word_q      <= word_d;
      tlast_q     <= tlast_d;
      ts_q        <= ts_d;
      has_time_q  <= has_time_d;
      eov_q       <= eov_d;
      eob_q       <= eob_d;
      msb_q       <= msb_d;
      full_q      <= full_d;
      idx_q       <= idx_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign s_axis_tready     = s_rdy;
  assign m_axis_tvalid     = full_q;
  assign m_axis_tdata      = OUT_W'(sym);
  assign m_axis_tlast      = tlast_q && at_last;
  assign m_axis_ttimestamp = ts_q;
  assign m_axis_thas_time  = has_time_q;
  assign m_axis_teov       = eov_q;
  assign m_axis_teob       = eob_q;
  assign sym_count         = sym_count_q;

endmodule

// File: tb/tb_axis_symbol_unpacker.sv
// Testbench for axis_symbol_unpacker: directed scenarios plus a randomized
// stream checked against a queue-based symbol model.
module tb_axis_symbol_unpacker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cfg_msb;
  logic [31:0] s_tdata;
  logic        s_tlast, s_tvalid, s_tready;
  logic [63:0] s_ts;
  logic        s_has_time, s_eov, s_eob;
  logic [31:0] m_tdata;
  logic        m_tlast, m_tvalid, m_tready;
  logic [63:0] m_ts;
  logic        m_has_time, m_eov, m_eob;
  logic [31:0] sym_count;

  logic        d4_cfg;
  logic [15:0] d4_s_tdata;
  logic        d4_s_tlast, d4_s_tvalid, d4_s_tready;
  logic [63:0] d4_s_ts;
  logic        d4_s_ht, d4_s_eov, d4_s_eob;
  logic [7:0]  d4_m_tdata;
  logic        d4_m_tlast, d4_m_tvalid, d4_m_tready;
  logic [63:0] d4_m_ts;
  logic        d4_m_ht, d4_m_eov, d4_m_eob;
  logic [31:0] d4_count;

  axis_symbol_unpacker #(.ITEM_W(32), .SYM_W(2), .OUT_W(32)) u_dut (
    .axis_data_clk(clk), .axis_data_rst_n(rst_n), .cfg_msb_first(cfg_msb),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_ttimestamp(s_ts), .s_axis_thas_time(s_has_time),
    .s_axis_teov(s_eov), .s_axis_teob(s_eob),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_ttimestamp(m_ts), .m_axis_thas_time(m_has_time),
    .m_axis_teov(m_eov), .m_axis_teob(m_eob), .sym_count(sym_count)
  );

  axis_symbol_unpacker #(.ITEM_W(16), .SYM_W(4), .OUT_W(8)) u_dut4 (
    .axis_data_clk(clk), .axis_data_rst_n(rst_n), .cfg_msb_first(d4_cfg),
    .s_axis_tdata(d4_s_tdata), .s_axis_tlast(d4_s_tlast), .s_axis_tvalid(d4_s_tvalid),
    .s_axis_tready(d4_s_tready), .s_axis_ttimestamp(d4_s_ts), .s_axis_thas_time(d4_s_ht),
    .s_axis_teov(d4_s_eov), .s_axis_teob(d4_s_eob),
    .m_axis_tdata(d4_m_tdata), .m_axis_tlast(d4_m_tlast), .m_axis_tvalid(d4_m_tvalid),
    .m_axis_tready(d4_m_tready), .m_axis_ttimestamp(d4_m_ts), .m_axis_thas_time(d4_m_ht),
    .m_axis_teov(d4_m_eov), .m_axis_teob(d4_m_eob), .sym_count(d4_count)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_count = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [63:0] ts;
    logic        ht, eov, eob;
  } exp_t;
  exp_t exp_q[$];

  // Symbol k of a 32-bit item with 2-bit symbols, by plain shifting.
  function automatic logic [31:0] sym32(logic [31:0] item, int k, logic msb);
    int sh;
    sh = msb ? (32 - (k + 1) * 2) : (k * 2);
    return (item >> sh) & 32'h3;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; cfg_msb = 1'b1; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    s_ts = '0; s_has_time = 1'b0; s_eov = 1'b0; s_eob = 1'b0; m_tready = 1'b0;
    d4_cfg = 1'b1; d4_s_tdata = '0; d4_s_tlast = 1'b0; d4_s_tvalid = 1'b0;
    d4_s_ts = '0; d4_s_ht = 1'b0; d4_s_eov = 1'b0; d4_s_eob = 1'b0; d4_m_tready = 1'b0;
    #2;
    n_cmp++;
    if ({m_tvalid, m_tlast, m_has_time, m_eov, m_eob} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {m_tvalid, m_tlast, m_has_time, m_eov, m_eob});
    end
    n_cmp++;
    if (m_tdata !== 32'd0 || m_ts !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", m_tdata, m_ts);
    end
    n_cmp++;
    if (sym_count !== 32'd0 || d4_m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_count: got %0d/%b expected 0/0", sym_count, d4_m_tvalid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    @(negedge clk); #1;
    n_cmp++;
    if (s_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_tready: got %b expected 1", s_tready);
    end
  endtask

  task automatic test_msb_first();
    logic [31:0] expv;
    @(negedge clk);
    cfg_msb = 1'b1; s_tdata = 32'hE400_0000; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    #1;
    n_cmp++;
    if (s_tready !== 1'b1) begin
      n_fail++; $display("FAIL msb_load_ready: got %b expected 1", s_tready);
    end
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      expv = (k < 4) ? 32'(3 - k) : 32'd0;
      n_cmp++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, (k == 15), expv}) begin
        n_fail++; $display("FAIL msb_sym%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                           k, m_tvalid, m_tlast, m_tdata, (k == 15), expv);
      end
      exp_count++;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || sym_count !== exp_count) begin
      n_fail++; $display("FAIL msb_end: got v=%b cnt=%0d expected v=0 cnt=%0d", m_tvalid, sym_count, exp_count);
    end
  endtask

  task automatic test_lsb_first_toggle();
    logic [31:0] expv;
    @(negedge clk);
    cfg_msb = 1'b0; s_tdata = 32'h0000_00E4; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      expv = (k < 4) ? 32'(k) : 32'd0;
      n_cmp++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, (k == 15), expv}) begin
        n_fail++; $display("FAIL lsb_sym%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                           k, m_tvalid, m_tlast, m_tdata, (k == 15), expv);
      end
      exp_count++;
      if (k == 1) cfg_msb = 1'b1;
      if (k == 6) cfg_msb = 1'b0;
      if (k == 9) cfg_msb = 1'b1;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL lsb_end: got v=%b expected v=0", m_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv;
    @(negedge clk);
    cfg_msb = 1'b1; s_tdata = 32'hFFFF_FFFF; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    s_tdata = 32'h0000_0000; s_tlast = 1'b1;
    for (int k = 0; k < 32; k++) begin
      #1;
      expv = (k < 16) ? 32'd3 : 32'd0;
      n_cmp++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, (k == 31), expv}) begin
        n_fail++; $display("FAIL b2b_sym%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                           k, m_tvalid, m_tlast, m_tdata, (k == 31), expv);
      end
      if (k < 16) begin
        n_cmp++;
        if (s_tready !== (k == 15)) begin
          n_fail++; $display("FAIL b2b_tready%0d: got %b expected %b", k, s_tready, (k == 15));
        end
      end
      exp_count++;
      @(negedge clk);
      if (k == 15) begin s_tvalid = 1'b0; s_tlast = 1'b0; end
    end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || sym_count !== exp_count) begin
      n_fail++; $display("FAIL b2b_end: got v=%b cnt=%0d expected v=0 cnt=%0d", m_tvalid, sym_count, exp_count);
    end
  endtask

  task automatic test_sideband();
    logic [31:0] item;
    item = $urandom;
    @(negedge clk);
    cfg_msb = 1'b1; s_tdata = item; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    s_ts = 64'h1234_5678_9ABC_DEF0; s_has_time = 1'b1; s_eob = 1'b1; s_eov = 1'b0;
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    s_ts = {$urandom, $urandom}; s_has_time = 1'b0; s_eob = 1'b0; s_eov = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_cmp++;
      if ({m_tvalid, m_ts, m_has_time, m_eob, m_eov} !== {1'b1, 64'h1234_5678_9ABC_DEF0, 3'b110}) begin
        n_fail++; $display("FAIL side_sym%0d: got v=%b ts=%h ht=%b eob=%b eov=%b expected v=1 ts=123456789abcdef0 ht=1 eob=1 eov=0",
                           k, m_tvalid, m_ts, m_has_time, m_eob, m_eov);
      end
      n_cmp++;
      if (m_tdata !== sym32(item, k, 1'b1)) begin
        n_fail++; $display("FAIL side_data%0d: got %h expected %h", k, m_tdata, sym32(item, k, 1'b1));
      end
      exp_count++;
      @(negedge clk);
    end
    s_eov = 1'b0;
  endtask

  task automatic test_random();
    localparam int N_ITEMS = 1000;
    localparam int BOUND   = 60000;
    int          sent = 0;
    int          cyc = 0;
    bit          have = 0;
    bit          stall_prev = 0;
    logic [100:0] prev_v, cur_v;
    exp_t        e;
    while ((sent < N_ITEMS || have || exp_q.size() > 0) && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      m_tready = 1'($urandom_range(0, 1));
      cfg_msb  = 1'($urandom_range(0, 1));
      if (!have) begin
        s_tvalid = 1'b0;
        if (sent < N_ITEMS) begin
          s_tdata = $urandom; s_tlast = 1'($urandom_range(0, 1));
          s_ts = {$urandom, $urandom}; s_has_time = 1'($urandom_range(0, 1));
          s_eov = 1'($urandom_range(0, 1)); s_eob = 1'($urandom_range(0, 1));
          s_tvalid = 1'b1; have = 1;
        end
      end
      #1;
      cur_v = {m_tvalid, m_tdata, m_tlast, m_ts, m_has_time, m_eov, m_eob};
      if (stall_prev) begin
        n_cmp++;
        if (cur_v !== prev_v) begin
          n_fail++; $display("FAIL rnd_stall cyc%0d: got %h expected %h", cyc, cur_v, prev_v);
        end
      end
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra cyc%0d: got d=%h expected no output", cyc, m_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({m_tdata, m_tlast, m_ts, m_has_time, m_eov, m_eob} !== {e.data, e.last, e.ts, e.ht, e.eov, e.eob}) begin
            n_fail++; $display("FAIL rnd_beat cyc%0d: got d=%h l=%b ts=%h sb=%b%b%b expected d=%h l=%b ts=%h sb=%b%b%b",
                               cyc, m_tdata, m_tlast, m_ts, m_has_time, m_eov, m_eob,
                               e.data, e.last, e.ts, e.ht, e.eov, e.eob);
          end
        end
        exp_count++;
      end
      stall_prev = m_tvalid && !m_tready;
      prev_v = cur_v;
      if (s_tvalid && s_tready) begin
        for (int k = 0; k < 16; k++) begin
          e.data = sym32(s_tdata, k, cfg_msb);
          e.last = s_tlast && (k == 15);
          e.ts = s_ts; e.ht = s_has_time; e.eov = s_eov; e.eob = s_eob;
          exp_q.push_back(e);
        end
        sent++;
        have = 0;
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    n_cmp++;
    if (cyc >= BOUND || sent != N_ITEMS || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_done: got cyc=%0d sent=%0d left=%0d expected cyc<%0d sent=%0d left=0",
                         cyc, sent, exp_q.size(), BOUND, N_ITEMS);
    end
    n_cmp++;
    if (sym_count !== exp_count) begin
      n_fail++; $display("FAIL rnd_count: got %0d expected %0d", sym_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] expv;
    @(negedge clk);
    cfg_msb = 1'b1; s_tdata = $urandom; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || sym_count !== 32'd0) begin
      n_fail++; $display("FAIL midrst_assert: got v=%b cnt=%0d expected v=0 cnt=0", m_tvalid, sym_count);
    end
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_release: got v=%b rdy=%b expected v=0 rdy=1", m_tvalid, s_tready);
    end
    s_tdata = 32'hE400_0000; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      expv = (k < 4) ? 32'(3 - k) : 32'd0;
      n_cmp++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, (k == 15), expv}) begin
        n_fail++; $display("FAIL midrst_sym%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                           k, m_tvalid, m_tlast, m_tdata, (k == 15), expv);
      end
      exp_count++;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (sym_count !== exp_count) begin
      n_fail++; $display("FAIL midrst_count: got %0d expected %0d", sym_count, exp_count);
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] expv;
    @(negedge clk);
    d4_cfg = 1'b1; d4_s_tdata = 16'hABCD; d4_s_tlast = 1'b1; d4_s_tvalid = 1'b1; d4_m_tready = 1'b1;
    @(negedge clk);
    d4_s_tvalid = 1'b0; d4_s_tlast = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      expv = 8'(10 + k);
      n_cmp++;
      if ({d4_m_tvalid, d4_m_tlast, d4_m_tdata} !== {1'b1, (k == 3), expv}) begin
        n_fail++; $display("FAIL sweep_sym%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                           k, d4_m_tvalid, d4_m_tlast, d4_m_tdata, (k == 3), expv);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (d4_m_tvalid !== 1'b0 || d4_count !== 32'd4) begin
      n_fail++; $display("FAIL sweep_end: got v=%b cnt=%0d expected v=0 cnt=4", d4_m_tvalid, d4_count);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first_toggle();
    test_back_to_back();
    test_sideband();
    test_random();
    test_reset_mid_word();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
